// File: rtl/usb_sof_tx_scheduler.sv
// usb_sof_tx_scheduler: owns the USB frame timer, emits 3-byte SOF packets on the
// SIE Tx port, and arbitrates that port with one external transaction engine (SOF wins).
// Optional macro SOF_OVERRUN_CNT_EN builds a saturating count of frame wraps missed while an SOF was pending.
module usb_sof_tx_scheduler #(
  parameter int         FRAME_CLKS     = 48000,
  parameter int         GUARD_CLKS     = 2000,
  parameter logic [7:0] SOF_CTRL_START = 8'h01,
  parameter logic [7:0] SOF_CTRL_DATA  = 8'h02,
  parameter logic [7:0] PID_SOF        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sofEnable,
  output logic [10:0] frameNum,
  output logic        sofSent,
  output logic        sofGuard,
  input  logic        txnReq,
  output logic        txnGnt,
  input  logic [7:0]  txnCtrlIn,
  input  logic [7:0]  txnDataIn,
  input  logic        txnWEn,
  output logic        txnRdy,
  output logic [7:0]  SIEPortCtrlOut,
  output logic [7:0]  SIEPortDataOut,
  output logic        SIEPortWEn,
  input  logic        SIEPortTxRdy,
  output logic [7:0]  sofOverrunCnt
);

  localparam int            CW          = $clog2(FRAME_CLKS);
  localparam logic [CW-1:0] LAST_CNT    = CW'(FRAME_CLKS - 1);
  localparam logic [CW-1:0] GUARD_START = CW'(FRAME_CLKS - GUARD_CLKS);

  typedef enum logic [1:0] {IDLE, SOF_WR, SOF_GAP, TXN} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_count;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [10:0]   r_frame_num;
  logic          r_pending, r_guard, r_gnt, r_sof_sent, r_wen;
  logic [7:0]    r_ctrl, r_data;
  logic          w_wen, w_wrap, w_sof_done;
  logic [7:0]    w_ctrl, w_data;

  assign w_wrap = sofEnable && (r_count == LAST_CNT);

  // Frame timer, guard window and pending-SOF flag; a wrap outranks a same-cycle SOF completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_guard   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_guard <= sofEnable && (r_count >= GUARD_START);
      if (!sofEnable || w_wrap) r_count <= '0;
      else                      r_count <= r_count + 1'b1;
      if (!sofEnable)       r_pending <= 1'b0;
      else if (w_wrap)      r_pending <= 1'b1;
      else if (w_sof_done)  r_pending <= 1'b0;
    end
  end

  // Next-state and port-write decision; SOF bytes only leave from SOF_WR, so writes are never back to back.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wen       = 1'b0;
    w_ctrl      = 8'h00;
    w_data      = 8'h00;
    w_sof_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_state_nxt = SOF_WR;
          w_idx_nxt   = 2'd0;
        end else if (txnReq && !r_guard) begin
          w_state_nxt = TXN;
        end
      end
      SOF_WR: begin
        if (SIEPortTxRdy) begin
          w_wen       = 1'b1;
          w_state_nxt = SOF_GAP;
          case (r_idx)
            2'd0: begin w_ctrl = SOF_CTRL_START; w_data = PID_SOF;                    end
            2'd1: begin w_ctrl = SOF_CTRL_DATA;  w_data = r_frame_num[7:0];           end
            default: begin w_ctrl = SOF_CTRL_DATA; w_data = {5'b0, r_frame_num[10:8]}; end
          endcase
        end
      end
      SOF_GAP: begin
        if (r_idx == 2'd2) begin
          w_sof_done  = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = IDLE;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = SOF_WR;
        end
      end
      TXN: begin
        w_wen  = txnWEn & r_gnt;
        w_ctrl = txnCtrlIn;
        w_data = txnDataIn;
        if (!txnReq) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, registered SIE port outputs, grant, frame number and sent pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_frame_num <= 11'd0;
      r_gnt       <= 1'b0;
      r_sof_sent  <= 1'b0;
      r_wen       <= 1'b0;
      r_ctrl      <= 8'h00;
      r_data      <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_gnt      <= (w_state_nxt == TXN);
      r_sof_sent <= w_sof_done;
      r_wen      <= w_wen;
      r_ctrl     <= w_ctrl;
      r_data     <= w_data;
      if (w_sof_done) r_frame_num <= r_frame_num + 11'd1;
    end
  end

`ifdef SOF_OVERRUN_CNT_EN
  logic [7:0] r_overrun;

  // Count frame boundaries that arrive while the previous SOF is still waiting; saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       r_overrun <= 8'h00;
    else if (w_wrap && r_pending && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'h01;
  end

  assign sofOverrunCnt = r_overrun;
`else
  assign sofOverrunCnt = 8'h00;
`endif

  assign frameNum       = r_frame_num;
  assign sofSent        = r_sof_sent;
  assign sofGuard       = r_guard;
  assign txnGnt         = r_gnt;
  assign txnRdy         = SIEPortTxRdy & r_gnt;
  assign SIEPortCtrlOut = r_ctrl;
  assign SIEPortDataOut = r_data;
  assign SIEPortWEn     = r_wen;

endmodule

// File: tb/tb_usb_sof_tx_scheduler.sv
// Directed bench for usb_sof_tx_scheduler with FRAME_CLKS=100, GUARD_CLKS=20.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected SOF bytes, timings and counts are hand-derived from the frame/arbiter behaviour.
module tb_usb_sof_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst, sofEnable, txnReq, txnWEn, SIEPortTxRdy;
  logic [7:0]  txnCtrlIn, txnDataIn;
  logic [10:0] frameNum;
  logic        sofSent, sofGuard, txnGnt, txnRdy, SIEPortWEn;
  logic [7:0]  SIEPortCtrlOut, SIEPortDataOut, sofOverrunCnt;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int t0 = 0;

  usb_sof_tx_scheduler #(.FRAME_CLKS(100), .GUARD_CLKS(20)) dut (
    .clk(clk), .rst(rst), .sofEnable(sofEnable), .frameNum(frameNum),
    .sofSent(sofSent), .sofGuard(sofGuard), .txnReq(txnReq), .txnGnt(txnGnt),
    .txnCtrlIn(txnCtrlIn), .txnDataIn(txnDataIn), .txnWEn(txnWEn), .txnRdy(txnRdy),
    .SIEPortCtrlOut(SIEPortCtrlOut), .SIEPortDataOut(SIEPortDataOut),
    .SIEPortWEn(SIEPortWEn), .SIEPortTxRdy(SIEPortTxRdy), .sofOverrunCnt(sofOverrunCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rel(input int k);
    while (cyc - t0 < k) @(negedge clk);
  endtask

  // Hold reset for two cycles, check everything is quiet, release with the timer enabled.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; sofEnable = 1'b0; txnReq = 1'b0; txnWEn = 1'b0;
    txnCtrlIn = 8'h00; txnDataIn = 8'h00; SIEPortTxRdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_wen",   SIEPortWEn, 1'b0);
    check("rst_ctrl",  SIEPortCtrlOut, 8'h00);
    check("rst_data",  SIEPortDataOut, 8'h00);
    check("rst_frame", frameNum, 11'd0);
    check("rst_sent",  sofSent, 1'b0);
    check("rst_guard", sofGuard, 1'b0);
    check("rst_gnt",   txnGnt, 1'b0);
    check("rst_rdy",   txnRdy, 1'b0);
    check("rst_ovr",   sofOverrunCnt, 8'h00);
    rst = 1'b1; sofEnable = 1'b1;
    t0 = cyc;
  endtask

  // Wait (bounded) for one write, check it, then check the following cycle carries no write.
  task automatic wait_byte(input string tag, input logic [7:0] c, input logic [7:0] d, output int at_rel);
    int n = 0;
    while (SIEPortWEn !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    at_rel = cyc - t0;
    check({tag, "_wen"},  SIEPortWEn, 1'b1);
    check({tag, "_ctrl"}, SIEPortCtrlOut, c);
    check({tag, "_data"}, SIEPortDataOut, d);
    @(negedge clk);
    check({tag, "_gap"},  SIEPortWEn, 1'b0);
  endtask

  // Remaining bytes 1 and 2 of an SOF for frame fn, then the sent pulse and frame increment.
  task automatic sof_tail(input string tag, input logic [10:0] fn);
    logic [10:0] fn1;
    int r;
    fn1 = fn + 11'd1;
    wait_byte({tag, "_b1"}, 8'h02, fn[7:0], r);
    wait_byte({tag, "_b2"}, 8'h02, {5'b0, fn[10:8]}, r);
    check({tag, "_sent"},  sofSent, 1'b1);
    check({tag, "_frame"}, frameNum, fn1);
    @(negedge clk);
    check({tag, "_sent_pulse"}, sofSent, 1'b0);
  endtask

  task automatic expect_sof(input string tag, input logic [10:0] fn, output int first_rel);
    wait_byte({tag, "_b0"}, 8'h01, 8'hA5, first_rel);
    sof_tail(tag, fn);
  endtask

  initial begin
    int r;
    int seen;
    logic [7:0] ovr_exp;

    // 1: first SOF of frame 0 after a full frame; guard window edges.
    do_reset();
    wait_rel(80);
    check("t1_guard_before", sofGuard, 1'b0);
    wait_rel(81);
    check("t1_guard_in", sofGuard, 1'b1);
    wait_rel(100);
    check("t1_no_early_wr", SIEPortWEn, 1'b0);
    expect_sof("t1", 11'd0, r);
    check("t1_first_rel", r, 102);

    // 2: frame number 2047 sends high bits 7 and wraps to 0.
    do_reset();
    wait_rel(50);
    force dut.r_frame_num = 11'd2047;
    @(negedge clk);
    release dut.r_frame_num;
    check("t2_forced", frameNum, 11'd2047);
    expect_sof("t2", 11'd2047, r);

    // 3a: request inside guard window is held off until after the SOF.
    do_reset();
    wait_rel(85);
    txnReq = 1'b1;
    wait_rel(99);
    check("t3a_no_gnt_guard", txnGnt, 1'b0);
    expect_sof("t3a", 11'd0, r);
    check("t3a_gnt_after_sof", txnGnt, 1'b1);
    txnReq = 1'b0;
    @(negedge clk);
    check("t3a_gnt_release", txnGnt, 1'b0);

    // 3b: early request granted next cycle; writes pass through only once granted.
    do_reset();
    wait_rel(10);
    txnReq = 1'b1; txnWEn = 1'b1; txnCtrlIn = 8'h5C; txnDataIn = 8'h3E;
    check("t3b_gnt_latency", txnGnt, 1'b0);
    @(negedge clk);
    check("t3b_gnt", txnGnt, 1'b1);
    check("t3b_idle_wen_ignored", SIEPortWEn, 1'b0);
    check("t3b_rdy", txnRdy, 1'b1);
    @(negedge clk);
    check("t3b_wen", SIEPortWEn, 1'b1);
    check("t3b_ctrl", SIEPortCtrlOut, 8'h5C);
    check("t3b_data", SIEPortDataOut, 8'h3E);
    txnWEn = 1'b0; txnCtrlIn = 8'h77; txnDataIn = 8'h88; SIEPortTxRdy = 1'b0;
    #1;
    check("t3b_rdy_follows", txnRdy, 1'b0);
    @(negedge clk);
    check("t3b_wen_off", SIEPortWEn, 1'b0);
    check("t3b_data2", SIEPortDataOut, 8'h88);
    SIEPortTxRdy = 1'b1; txnReq = 1'b0;

    // 4: transaction spanning the boundary defers the SOF; frame advances once.
    do_reset();
    wait_rel(50);
    txnReq = 1'b1;
    wait_rel(129);
    check("t4_gnt_held", txnGnt, 1'b1);
    check("t4_no_sof_frame", frameNum, 11'd0);
    wait_rel(130);
    txnReq = 1'b0;
    expect_sof("t4", 11'd0, r);
    check("t4_first_rel", r, 133);

    // 5: Tx not ready during SOF byte 1 stalls it; async reset mid-SOF clears outputs.
    do_reset();
    wait_byte("t5_b0", 8'h01, 8'hA5, r);
    SIEPortTxRdy = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (SIEPortWEn !== 1'b0) seen++;
    end
    check("t5_stall_no_wen", seen, 0);
    SIEPortTxRdy = 1'b1;
    sof_tail("t5", 11'd0);
    wait_byte("t5_next_b0", 8'h01, 8'hA5, r);
    wait_rel(r + 2);
    check("t5_pre_rst_wen", SIEPortWEn, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("t5_arst_wen", SIEPortWEn, 1'b0);
    check("t5_arst_ctrl", SIEPortCtrlOut, 8'h00);
    check("t5_arst_data", SIEPortDataOut, 8'h00);
    check("t5_arst_frame", frameNum, 11'd0);

    // 6: two wraps while pending -> overrun count, single SOF; then timer disabled.
    do_reset();
    wait_rel(10);
    txnReq = 1'b1;
    wait_rel(260);
    txnReq = 1'b0;
    expect_sof("t6", 11'd0, r);
`ifdef SOF_OVERRUN_CNT_EN
    ovr_exp = 8'h01;
`else
    ovr_exp = 8'h00;
`endif
    check("t6_overrun", sofOverrunCnt, ovr_exp);
    sofEnable = 1'b0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (SIEPortWEn !== 1'b0) seen++;
    end
    check("t6_disabled_no_sof", seen, 0);
    check("t6_disabled_frame", frameNum, 11'd1);
    check("t6_disabled_guard", sofGuard, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
